// File: rtl/letter_pkg.sv
// Shared definitions for the 3-bit column letter protocol: letter codes, glyph column tables,
// glyph lengths and the writer state encoding.
package letter_pkg;

  localparam int unsigned ColW     = 3;
  localparam int unsigned MaxGlyph = 4;

  typedef logic [ColW-1:0]          col_t;
  typedef logic [MaxGlyph*ColW-1:0] glyph_t;

  typedef enum logic [1:0] {
    LTR_L = 2'b00,
    LTR_I = 2'b01,
    LTR_T = 2'b10,
    LTR_U = 2'b11
  } letter_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_e;

  // Column 0 sits in the least significant bits; unused trailing columns are 000.
  localparam glyph_t GlyphL = {3'b000, 3'b000, 3'b001, 3'b111};
  localparam glyph_t GlyphI = {3'b000, 3'b000, 3'b000, 3'b111};
  localparam glyph_t GlyphT = {3'b000, 3'b100, 3'b111, 3'b100};
  localparam glyph_t GlyphU = {3'b000, 3'b111, 3'b001, 3'b111};

  function automatic glyph_t glyph_cols(input letter_e l);
    glyph_t g;
    unique case (l)
      LTR_L:   g = GlyphL;
      LTR_I:   g = GlyphI;
      LTR_T:   g = GlyphT;
      default: g = GlyphU;
    endcase
    return g;
  endfunction

  // Length includes the trailing 000 separator column.
  function automatic logic [2:0] glyph_len(input letter_e l);
    logic [2:0] n;
    unique case (l)
      LTR_L:   n = 3'd3;
      LTR_I:   n = 3'd2;
      LTR_T:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/letter_glyph_rom.sv
// Combinational glyph lookup: (letter, column index) -> column bits and separator flag.
module letter_glyph_rom
  import letter_pkg::*;
(
  input  letter_e    letter_i,
  input  logic [1:0] col_i,
  output col_t       column_o,
  output logic       is_last_o
);

  glyph_t     glyph;
  logic [2:0] len;

  always_comb begin
    glyph     = glyph_cols(letter_i);
    len       = glyph_len(letter_i);
    column_o  = glyph[int'(col_i) * ColW +: ColW];
    // Indices past the glyph also report last so a stray index can never run on.
    is_last_o = ({1'b0, col_i} >= (len - 3'd1));
  end

endmodule

// File: rtl/l_writer.sv
// Serialises letter requests into the 3-bit column stream, one column per clock, with a one-entry
// pending slot so consecutive glyphs can run back-to-back.
module l_writer
  import letter_pkg::*;
#(
  parameter int unsigned GAP_COLS = 0
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       req_valid,
  input  logic [1:0] req_letter,
  output logic       req_ready,
  output logic [2:0] bits,
  output logic       busy,
  output logic       letter_done
);

  localparam logic [2:0] GapLast = (GAP_COLS == 0) ? 3'd0 : 3'(GAP_COLS - 1);

  state_e     state_q, state_d;
  letter_e    letter_q, letter_d;
  logic [1:0] col_q, col_d;
  logic [2:0] gap_q, gap_d;
  logic       pend_full_q, pend_full_d;
  letter_e    pend_letter_q, pend_letter_d;
  col_t       bits_q, bits_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       accept;
  logic       end_of_unit;
  logic       start;
  letter_e    start_letter;
  col_t       rom_col;
  logic       rom_last;

  letter_glyph_rom u_rom (
    .letter_i  (letter_d),
    .col_i     (col_d),
    .column_o  (rom_col),
    .is_last_o (rom_last)
  );

  always_comb begin
    accept        = req_valid & ready_q;
    state_d       = state_q;
    letter_d      = letter_q;
    col_d         = col_q;
    gap_d         = gap_q;
    pend_full_d   = pend_full_q;
    pend_letter_d = pend_letter_q;
    end_of_unit   = 1'b0;
    start         = 1'b0;
    start_letter  = pend_letter_q;

    unique case (state_q)
      IDLE: end_of_unit = 1'b1;
      SEND: begin
        // done_q marks that the separator column is currently on the bus.
        if (!done_q) begin
          col_d = col_q + 2'd1;
        end else if (GAP_COLS > 0) begin
          state_d = GAP;
          gap_d   = 3'd0;
        end else begin
          end_of_unit = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GapLast) begin
          end_of_unit = 1'b1;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_of_unit) begin
      if (pend_full_q) begin
        start        = 1'b1;
        start_letter = pend_letter_q;
        pend_full_d  = accept;
      end else if (accept) begin
        start        = 1'b1;
        start_letter = letter_e'(req_letter);
      end else begin
        state_d = IDLE;
      end
    end else if (accept) begin
      pend_full_d = 1'b1;
    end

    if (accept) begin
      pend_letter_d = letter_e'(req_letter);
    end

    if (start) begin
      state_d  = SEND;
      letter_d = start_letter;
      col_d    = 2'd0;
    end

    bits_d  = (state_d == SEND) ? rom_col : '0;
    done_d  = (state_d == SEND) && rom_last;
    busy_d  = (state_d != IDLE);
    ready_d = !pend_full_d;
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q       <= IDLE;
      letter_q      <= LTR_L;
      col_q         <= 2'd0;
      gap_q         <= 3'd0;
      pend_full_q   <= 1'b0;
      pend_letter_q <= LTR_L;
      bits_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      letter_q      <= letter_d;
      col_q         <= col_d;
      gap_q         <= gap_d;
      pend_full_q   <= pend_full_d;
      pend_letter_q <= pend_letter_d;
      bits_q        <= bits_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
    end
  end

  assign req_ready   = ready_q;
  assign bits        = bits_q;
  assign busy        = busy_q;
  assign letter_done = done_q;

endmodule

// File: tb/tb_l_writer.sv
// Bench for l_writer: directed glyph sequences on two instances (no gap, two gap columns) plus
// randomized traffic checked against a queue-based model of the column stream.
module tb_l_writer;

  logic       clk = 1'b0;
  logic       restart = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_letter = 2'b00;

  logic       rdy0, busy0, done0;
  logic [2:0] bits0;
  logic       rdy1, busy1, done1;
  logic [2:0] bits1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l_writer #(.GAP_COLS(0)) u_dut0 (
    .clk         (clk),
    .restart     (restart),
    .req_valid   (req_valid),
    .req_letter  (req_letter),
    .req_ready   (rdy0),
    .bits        (bits0),
    .busy        (busy0),
    .letter_done (done0)
  );

  l_writer #(.GAP_COLS(2)) u_dut1 (
    .clk         (clk),
    .restart     (restart),
    .req_valid   (req_valid),
    .req_letter  (req_letter),
    .req_ready   (rdy1),
    .bits        (bits1),
    .busy        (busy1),
    .letter_done (done1)
  );

  // Model: a queue of columns still to appear on the bus, plus accepted letters not yet started.
  typedef struct packed {
    logic [2:0] col;
    logic       sep;
  } ent_t;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [1:0] p0[$];
  logic [1:0] p1[$];
  logic       rdy_m0 = 1'b0;
  logic       rdy_m1 = 1'b0;

  function automatic int glyph_len(input logic [1:0] l);
    case (l)
      2'd0:    return 3;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] glyph_col(input logic [1:0] l, input int i);
    logic [2:0] t [4];
    case (l)
      2'd0:    t = '{3'b111, 3'b001, 3'b000, 3'b000};
      2'd1:    t = '{3'b111, 3'b000, 3'b000, 3'b000};
      2'd2:    t = '{3'b100, 3'b111, 3'b100, 3'b000};
      default: t = '{3'b111, 3'b001, 3'b111, 3'b000};
    endcase
    return t[i];
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    p0.delete();
    p1.delete();
    rdy_m0 = 1'b0;
    rdy_m1 = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] l);
    logic [1:0] nl;
    ent_t       e;
    if (q0.size() > 0) void'(q0.pop_front());
    if (v && rdy_m0) p0.push_back(l);
    if (q0.size() == 0 && p0.size() > 0) begin
      nl = p0.pop_front();
      for (int i = 0; i < glyph_len(nl); i++) begin
        e.col = glyph_col(nl, i);
        e.sep = (i == glyph_len(nl) - 1);
        q0.push_back(e);
      end
    end
    rdy_m0 = (p0.size() == 0);

    if (q1.size() > 0) void'(q1.pop_front());
    if (v && rdy_m1) p1.push_back(l);
    if (q1.size() == 0 && p1.size() > 0) begin
      nl = p1.pop_front();
      for (int i = 0; i < glyph_len(nl); i++) begin
        e.col = glyph_col(nl, i);
        e.sep = (i == glyph_len(nl) - 1);
        q1.push_back(e);
      end
      e = '0;
      repeat (2) q1.push_back(e);
    end
    rdy_m1 = (p1.size() == 0);
  endtask

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cycle(input logic v, input logic [1:0] l);
    req_valid  = v;
    req_letter = l;
    @(posedge clk);
    model_edge(v, l);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    restart   = 1'b0;
    req_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    restart = 1'b1;
    cycle(1'b0, 2'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bits0 !== 3'b000 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got bits=%b busy=%b done=%b want 000/0/0", bits0, busy0, done0);
    end
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b/%b want 0/0", rdy0, rdy1);
    end
    restart = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL release_ready_before_edge got %b want 0", rdy0);
    end
    @(negedge clk);
    cycle(1'b0, 2'd0);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1 || bits0 !== 3'b000 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release got rdy=%b/%b bits=%b busy=%b want 1/1 000 0",
               rdy0, rdy1, bits0, busy0);
    end
  endtask

  task automatic test_single_l();
    logic [2:0] eb [4] = '{3'b111, 3'b001, 3'b000, 3'b000};
    logic       ed [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       ey [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, 2'd0);
      checks++;
      if (bits0 !== eb[i] || done0 !== ed[i] || busy0 !== ey[i]) begin
        errors++;
        $display("FAIL single_l[%0d] got bits=%b done=%b busy=%b want %b/%b/%b",
                 i, bits0, done0, busy0, eb[i], ed[i], ey[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       vv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] ll [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [2:0] eb [5] = '{3'b111, 3'b001, 3'b000, 3'b111, 3'b000};
    logic       er [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ed [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(vv[i], ll[i]);
      checks++;
      if (bits0 !== eb[i] || rdy0 !== er[i] || done0 !== ed[i] || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d] got bits=%b rdy=%b done=%b busy=%b want %b/%b/%b/1",
                 i, bits0, rdy0, done0, busy0, eb[i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic [2:0] eb [9] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000,
                           3'b000};
    int         ndone = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(i < 2, 2'd1);
      if (done1 === 1'b1) ndone++;
      checks++;
      if (bits1 !== eb[i]) begin
        errors++;
        $display("FAIL gap_bits[%0d] got %b want %b", i, bits1, eb[i]);
      end
    end
    checks++;
    if (ndone != 2 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL gap_done_count got done=%0d busy=%b want 2/0", ndone, busy1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 2'd3);
    cycle(1'b1, 2'd0);
    cycle(1'b0, 2'd0);
    checks++;
    if (bits0 !== 3'b111) begin
      errors++;
      $display("FAIL async_precondition got %b want 111", bits0);
    end
    #2;
    restart = 1'b0;
    #1;
    checks++;
    if (bits0 !== 3'b000 || busy0 !== 1'b0 || rdy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got bits=%b busy=%b rdy=%b done=%b want 000/0/0/0",
               bits0, busy0, rdy0, done0);
    end
    model_clear();
    @(negedge clk);
    restart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd2);
      checks++;
      if (bits0 !== 3'b000 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
        errors++;
        $display("FAIL after_async[%0d] got bits=%b busy=%b rdy=%b want 000/0/1",
                 i, bits0, busy0, rdy0);
      end
    end
  endtask

  task automatic test_ignore_changes();
    logic       vv [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] ll [7] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [2:0] eb [7] = '{3'b100, 3'b111, 3'b100, 3'b000, 3'b111, 3'b000, 3'b000};
    logic       er [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(vv[i], ll[i]);
      checks++;
      if (bits0 !== eb[i] || rdy0 !== er[i]) begin
        errors++;
        $display("FAIL ignore[%0d] got bits=%b rdy=%b want %b/%b", i, bits0, rdy0, eb[i], er[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] xb0, xb1;
    logic       xd0, xd1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        restart = 1'b0;
        model_clear();
        @(negedge clk);
        restart = 1'b1;
      end else begin
        cycle($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)));
      end
      xb0 = (q0.size() > 0) ? q0[0].col : 3'b000;
      xd0 = (q0.size() > 0) ? q0[0].sep : 1'b0;
      xb1 = (q1.size() > 0) ? q1[0].col : 3'b000;
      xd1 = (q1.size() > 0) ? q1[0].sep : 1'b0;
      checks++;
      if (bits0 !== xb0 || done0 !== xd0 || busy0 !== (q0.size() > 0) || rdy0 !== rdy_m0) begin
        errors++;
        $display("FAIL rand0[%0d] got bits=%b done=%b busy=%b rdy=%b want %b/%b/%b/%b",
                 n, bits0, done0, busy0, rdy0, xb0, xd0, q0.size() > 0, rdy_m0);
      end
      checks++;
      if (bits1 !== xb1 || done1 !== xd1 || busy1 !== (q1.size() > 0) || rdy1 !== rdy_m1) begin
        errors++;
        $display("FAIL rand1[%0d] got bits=%b done=%b busy=%b rdy=%b want %b/%b/%b/%b",
                 n, bits1, done1, busy1, rdy1, xb1, xd1, q1.size() > 0, rdy_m1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_l();
    test_back_to_back();
    test_gap();
    test_async_reset();
    test_ignore_changes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
